mem_req_ctrl: RTL and testbench

//  Request controller placed directly upstream of single_port_memory; drives its mode/we/addr/data_in pins.

---
 rtl/mem_req_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request controller in front of a single-port memory: zero-fills the memory after reset or on
// clr, then runs one read or write at a time from a valid/ready request port to a valid/ready response port.
module mem_req_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_data,
   output logic              init_done,
   output logic              mem_mode,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [2:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // valid, once raised, holds its payload stable until that edge; ready never depends on valid.
   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_pend_q, clr_pend_d;
   logic              init_done_q, init_done_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              mem_mode_q, mem_mode_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              op_write_q, op_write_d;
   logic              req_ready_c;

   assign req_ready_c = (state_q == S_IDLE) && !rsp_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         clr_pend_q  <= 1'b0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_data_q  <= '0;
         mem_mode_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         op_write_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         clr_pend_q  <= clr_pend_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_data_q  <= rsp_data_d;
         mem_mode_q  <= mem_mode_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         op_write_q  <= op_write_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      clr_pend_d  = clr_pend_q | clr;
      init_done_d = init_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_data_d  = rsp_data_q;
      mem_mode_d  = mem_mode_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      op_write_d  = op_write_q;

      case (state_q)
         S_INIT: begin
            clr_pend_d = 1'b0;
            // The last word is on the pins once mem_we is high at ADDR_MAX; that edge ends the fill.
            if (mem_we_q && (mem_addr_q == ADDR_MAX)) begin
               mem_we_d    = 1'b0;
               init_done_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               mem_we_d   = 1'b1;
               mem_mode_d = 1'b0;
               mem_din_d  = '0;
               mem_addr_d = cnt_q;
               if (cnt_q != ADDR_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_IDLE: begin
            // A request already handshaken wins; any pending clear stays latched for the next IDLE.
            if (req_valid && req_ready_c) begin
               op_write_d = req_write;
               mem_addr_d = req_addr;
               if (req_write) begin
                  mem_we_d   = 1'b1;
                  mem_mode_d = 1'b0;
                  mem_din_d  = req_wdata;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_mode_d = 1'b1;
               end
               state_d = S_ISSUE;
            end else if (clr_pend_q || clr) begin
               init_done_d = 1'b0;
               cnt_d       = '0;
               clr_pend_d  = 1'b0;
               state_d     = S_INIT;
            end
         end

         S_ISSUE: begin
            mem_we_d = 1'b0;
            if (op_write_q) begin
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_data_d  = '0;
               state_d     = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            mem_we_d    = 1'b0;
            rsp_data_d  = mem_dout;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b0;
            state_d     = S_RESP;
         end

         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   assign req_ready = req_ready_c;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_data  = rsp_data_q;
   assign init_done = init_done_q;
   assign mem_mode  = mem_mode_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: behavioural memory, shadow array of expected contents,
// directed scenarios followed by randomized read/write/clear traffic.
module tb_mem_req_ctrl;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;

   logic              clk;
   logic              rst;
   logic              clr;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_data;
   logic              init_done;
   logic              mem_mode;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic [2:0]        dbg_state;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mem_model [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];

   mem_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_write (rsp_write),
      .rsp_data  (rsp_data),
      .init_done (init_done),
      .mem_mode  (mem_mode),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .dbg_state (dbg_state)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory: writes when we && mode==0, registered read data when mode==1.
   always @(posedge clk) begin
      if (mem_we && !mem_mode) mem_model[mem_addr] <= mem_din;
      if (mem_mode) mem_dout <= mem_model[mem_addr];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"},        mem_we,    1'b0);
      check({tag, "_mode"},      mem_mode,  1'b1);
      check({tag, "_addr"},      mem_addr,  '0);
      check({tag, "_din"},       mem_din,   '0);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rsp_write"}, rsp_write, 1'b0);
      check({tag, "_rsp_data"},  rsp_data,  '0);
      check({tag, "_init_done"}, init_done, 1'b0);
      check({tag, "_req_ready"}, req_ready, 1'b0);
   endtask

   // Called at a falling edge; `lead` idle cycles precede the first zero-fill write.
   task automatic check_init(input int lead);
      repeat (lead) begin
         check("init_lead_we", mem_we, 1'b0);
         check("init_lead_rsp_valid", rsp_valid, 1'b0);
         @(negedge clk);
      end
      for (int i = 0; i < DEPTH; i++) begin
         check("init_we",        mem_we,    1'b1);
         check("init_addr",      mem_addr,  i);
         check("init_din",       mem_din,   '0);
         check("init_mode",      mem_mode,  1'b0);
         check("init_done_low",  init_done, 1'b0);
         check("init_rsp_valid", rsp_valid, 1'b0);
         check("init_req_ready", req_ready, 1'b0);
         @(negedge clk);
      end
      check("init_end_we",        mem_we,    1'b0);
      check("init_end_done",      init_done, 1'b1);
      check("init_end_req_ready", req_ready, 1'b1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_q.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_values("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_init(1);
   endtask

   // Driver: one complete transaction starting at a falling edge in IDLE.
   task automatic do_op(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input int hold, input bit clr_in_resp);
      logic [DATA_W-1:0] exp;
      logic [DATA_W-1:0] got;
      check("op_req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
      exp_q.push_back(wr ? '0 : ref_mem[addr]);
      if (wr) ref_mem[addr] = data;
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = ADDR_W'($urandom);
      req_wdata = $urandom;
      rsp_ready = 1'($urandom_range(0, 1));
      check("issue_we",        mem_we,    wr);
      check("issue_mode",      mem_mode,  !wr);
      check("issue_addr",      mem_addr,  addr);
      if (wr) check("issue_din", mem_din, data);
      check("issue_rsp_valid", rsp_valid, 1'b0);
      check("issue_req_ready", req_ready, 1'b0);
      @(negedge clk);
      if (!wr) begin
         check("wait_rsp_valid", rsp_valid, 1'b0);
         check("wait_we",        mem_we,    1'b0);
         check("wait_req_ready", req_ready, 1'b0);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      exp = exp_q.pop_front();
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_write", rsp_write, wr);
      check("rsp_data",  rsp_data,  exp);
      check("rsp_we",    mem_we,    1'b0);
      got = rsp_data;
      if (clr_in_resp) clr = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         clr = 1'b0;
         check("hold_rsp_valid", rsp_valid, 1'b1);
         check("hold_rsp_data",  rsp_data,  got);
         check("hold_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      clr = 1'b0;
      check("done_rsp_valid", rsp_valid, 1'b0);
      check("done_req_ready", req_ready, 1'b1);
      if (clr_in_resp) check_init(2);
   endtask

   task automatic reset_mid_init();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("midinit_addr", mem_addr, 9);
      check("midinit_we",   mem_we,   1'b1);
      rst = 1'b1;
      #1;
      check_reset_values("midinit_rst");
      @(negedge clk);
      rst = 1'b0;
      check_init(1);
   endtask

   task automatic reset_mid_read(input logic [ADDR_W-1:0] addr);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = addr;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("midread_wait_rsp_valid", rsp_valid, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_values("midread_rst");
      @(negedge clk);
      check("midread_hold_rsp_valid", rsp_valid, 1'b0);
      rst = 1'b0;
      check_init(1);
   endtask

   // Stimulus
   initial begin
      rst       = 1'b1;
      clr       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

      apply_reset();

      do_op(1'b1, 5'd5, 32'd10, 0, 1'b0);
      do_op(1'b0, 5'd5, 32'd0, 0, 1'b0);
      do_op(1'b1, 5'd5, 32'd11, 0, 1'b0);
      do_op(1'b0, 5'd5, 32'd0, 0, 1'b0);
      do_op(1'b0, 5'd31, 32'd0, 0, 1'b0);
      do_op(1'b1, 5'd31, 32'hdead_beef, 2, 1'b0);
      do_op(1'b0, 5'd31, 32'd0, 4, 1'b0);
      do_op(1'b1, 5'd5, 32'd10, 1, 1'b1);
      do_op(1'b0, 5'd5, 32'd0, 0, 1'b0);
      do_op(1'b0, 5'd31, 32'd0, 0, 1'b0);

      do_op(1'b1, 5'd7, 32'h1234_5678, 0, 1'b0);
      reset_mid_init();
      do_op(1'b0, 5'd7, 32'd0, 0, 1'b0);
      do_op(1'b1, 5'd9, 32'h0bad_cafe, 0, 1'b0);
      reset_mid_read(5'd9);
      do_op(1'b0, 5'd9, 32'd0, 0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         logic [ADDR_W-1:0] a;
         case ($urandom_range(0, 3))
            0:       a = '0;
            1:       a = '1;
            default: a = ADDR_W'($urandom_range(0, 7));
         endcase
         do_op(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
